// File: rtl/alu_ctrl_pkg.sv
// Shared ALU definitions: data width, the 4-bit ALU control codes used by decode and EX,
// and the state encoding of the iterative multiply/divide engine.
package alu_ctrl_pkg;

    localparam int DATA_W = 32;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_MULT = 4'b0101;
    localparam logic [3:0] ALU_DIV  = 4'b1011;

    typedef enum logic [2:0] {
        MD_IDLE = 3'd0,
        MD_MUL  = 3'd1,
        MD_DIV  = 3'd2,
        MD_FIX  = 3'd3,
        MD_DONE = 3'd4
    } md_state_e;

    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? -v : v;
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// EX-stage ALU bus: operands and control from the pipeline, result/HI/LO/stall back to it.
interface alu_exec_unit_if;
    import alu_ctrl_pkg::*;

    logic              in_valid;
    logic              flush;
    logic [3:0]        alu_control;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              busy;
    logic              md_done;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output in_valid, flush, alu_control, src_a, src_b, shamt,
        input  result, zero, busy, md_done, hi, lo
    );

    modport slave (
        input  in_valid, flush, alu_control, src_a, src_b, shamt,
        output result, zero, busy, md_done, hi, lo
    );

endinterface

// File: rtl/alu_exec_unit_mul_div_seq.sv
// Iterative signed multiply/divide: magnitudes are processed one bit per cycle for 32 cycles,
// then signs are applied and HI/LO written in FIX; DONE pulses done_o for one cycle.
module mul_div_seq
    import alu_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              is_div,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              flush,
    output logic              idle_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    md_state_e           state_q, state_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   opnd_q, opnd_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic                neg_q, neg_d, rem_neg_q, rem_neg_d;
    logic                div0_q, div0_d, div_q, div_d;
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] div_shift;
    logic [DATA_W:0]     div_diff;
    logic [2*DATA_W-1:0] prod_fix;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        div0_d    = div0_q;
        div_d     = div_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        // MUL: acc = {partial product, remaining multiplier}; DIV: acc = {remainder, quotient}.
        mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
        div_shift = {acc_q[2*DATA_W-2:0], 1'b0};
        div_diff  = {1'b0, div_shift[2*DATA_W-1:DATA_W]} - {1'b0, opnd_q};
        prod_fix  = neg_q ? -acc_q : acc_q;

        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    state_d   = is_div ? MD_DIV : MD_MUL;
                    cnt_d     = '0;
                    opnd_d    = is_div ? abs_val(b) : abs_val(a);
                    acc_d     = {{DATA_W{1'b0}}, (is_div ? abs_val(a) : abs_val(b))};
                    neg_d     = a[DATA_W-1] ^ b[DATA_W-1];
                    rem_neg_d = a[DATA_W-1];
                    div0_d    = (b == '0);
                    div_d     = is_div;
                end
            end
            MD_MUL: begin
                acc_d = {mul_sum, acc_q[DATA_W-1:1]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = MD_FIX;
            end
            MD_DIV: begin
                acc_d = div_diff[DATA_W] ? div_shift
                                         : {div_diff[DATA_W-1:0], div_shift[DATA_W-1:1], 1'b1};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = MD_FIX;
            end
            MD_FIX: begin
                state_d = MD_DONE;
                if (div_q) begin
                    lo_d = div0_q ? '1 : (neg_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0]);
                    hi_d = rem_neg_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase

        // A flush abandons the operation, including a HI/LO write that FIX would make this cycle.
        if (flush && (state_q inside {MD_MUL, MD_DIV, MD_FIX})) begin
            state_d = MD_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // NOTE: datapath registers are always loaded on start before use, so they carry no reset.
    always_ff @(posedge clk) begin
        opnd_q    <= opnd_d;
        acc_q     <= acc_d;
        neg_q     <= neg_d;
        rem_neg_q <= rem_neg_d;
        div0_q    <= div0_d;
        div_q     <= div_d;
    end

    assign idle_o = (state_q == MD_IDLE);
    assign busy_o = (state_q inside {MD_MUL, MD_DIV, MD_FIX});
    assign done_o = (state_q == MD_DONE);
    assign hi     = hi_q;
    assign lo     = lo_q;

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: combinational single-cycle ops plus the iterative mult/div engine that owns HI/LO
// and stalls the pipeline through busy while it runs.
module alu_exec_unit
    import alu_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    alu_exec_unit_if.slave bus
);

    logic              op_mult, op_div, md_req;
    logic              md_idle, md_busy, md_done;
    logic [DATA_W-1:0] md_hi, md_lo;
    logic [DATA_W-1:0] alu_result;

    assign op_mult = (bus.alu_control == ALU_MULT);
    assign op_div  = (bus.alu_control == ALU_DIV);
    assign md_req  = bus.in_valid & ~bus.flush & (op_mult | op_div);

    mul_div_seq u_mul_div_seq (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_req),
        .is_div (op_div),
        .a      (bus.src_a),
        .b      (bus.src_b),
        .flush  (bus.flush),
        .idle_o (md_idle),
        .busy_o (md_busy),
        .done_o (md_done),
        .hi     (md_hi),
        .lo     (md_lo)
    );

    always_comb begin
        alu_result = '0;
        case (bus.alu_control)
            ALU_AND: alu_result = bus.src_a & bus.src_b;
            ALU_OR:  alu_result = bus.src_a | bus.src_b;
            ALU_ADD: alu_result = bus.src_a + bus.src_b;
            ALU_SUB: alu_result = bus.src_a - bus.src_b;
            ALU_NOR: alu_result = ~(bus.src_a | bus.src_b);
            ALU_XOR: alu_result = bus.src_a ^ bus.src_b;
            ALU_SLT: alu_result = {{(DATA_W-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
            ALU_SLL: alu_result = bus.src_b << bus.shamt;
            ALU_SRL: alu_result = bus.src_b >> bus.shamt;
            ALU_SRA: alu_result = DATA_W'($signed(bus.src_b) >>> bus.shamt);
            default: alu_result = '0;
        endcase
    end

    // The request only stalls in the accept cycle; in DONE the same instruction is let through.
    assign bus.busy    = (md_req & md_idle) | md_busy;
    assign bus.result  = alu_result;
    assign bus.zero    = (alu_result == '0);
    assign bus.md_done = md_done;
    assign bus.hi      = md_hi;
    assign bus.lo      = md_lo;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: table-driven single-cycle ops, randomized ops against a
// behavioural model, and hand-written mult/div timing, flush and reset sequences.
module tb_alu_exec_unit;

    localparam logic [3:0] C_AND = 4'b0000, C_OR  = 4'b0001, C_ADD = 4'b0010, C_SUB  = 4'b0110;
    localparam logic [3:0] C_NOR = 4'b1100, C_SLT = 4'b0111, C_XOR = 4'b0100, C_SLL  = 4'b1000;
    localparam logic [3:0] C_SRL = 4'b1001, C_SRA = 4'b1010, C_MUL = 4'b0101, C_DIV  = 4'b1011;

    typedef struct {
        logic [3:0]  code;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] res;
        logic        z;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_exec_unit_if bus();

    alu_exec_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
        int signed sb;
        longint la, lb;
        sb = b;
        la = $signed(a);
        lb = $signed(b);
        case (c)
            C_AND:   return a & b;
            C_OR:    return a | b;
            C_ADD:   return a + b;
            C_SUB:   return a - b;
            C_NOR:   return ~(a | b);
            C_XOR:   return a ^ b;
            C_SLT:   return (la < lb) ? 32'd1 : 32'd0;
            C_SLL:   return b << sh;
            C_SRL:   return b >> sh;
            C_SRA:   return sb >>> sh;
            default: return 32'd0;
        endcase
    endfunction

    task automatic md_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] hi, output logic [31:0] lo);
        longint la, lb, p, q, r;
        la = $signed(a);
        lb = $signed(b);
        if (c == C_MUL) begin
            p  = la * lb;
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
        end else begin
            q  = la / lb;
            r  = la % lb;
            hi = r[31:0];
            lo = q[31:0];
        end
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'd0;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one mult/div at the current cycle (inputs driven just after a rising edge) and check
    // busy length, md_done timing, HI/LO and that the engine returns to idle without restarting.
    task automatic run_md(input string tag, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input bit hold);
        int          busy_cnt;
        int          lat;
        logic [31:0] exp_hi, exp_lo;
        busy_cnt = 0;
        lat      = -1;
        md_model(c, a, b, exp_hi, exp_lo);
        bus.alu_control = c;
        bus.src_a       = a;
        bus.src_b       = b;
        bus.in_valid    = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            #1;
            if (bus.busy) busy_cnt++;
            if (bus.md_done) begin
                lat = cyc;
                break;
            end
            @(posedge clk);
            #1;
            if (!hold) bus.in_valid = 1'b0;
        end
        check({tag, "_latency"}, 64'(lat), 64'd34);
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd34);
        check({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        #1;
        check({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_done_pulse"}, 64'(bus.md_done), 64'd0);
    endtask

    initial begin
        vec_t        vecs [14];
        logic [3:0]  c;
        logic [31:0] a, b, exp, hold_hi, hold_lo;
        logic [4:0]  sh;
        int          done_seen;

        vecs[0]  = '{C_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000, 1'b0};
        vecs[1]  = '{C_SUB, 32'h0000_0005, 32'h0000_0005, 5'd0,  32'h0000_0000, 1'b1};
        vecs[2]  = '{C_NOR, 32'h0000_0000, 32'h0000_0000, 5'd0,  32'hFFFF_FFFF, 1'b0};
        vecs[3]  = '{C_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0001, 1'b0};
        vecs[4]  = '{C_SRA, 32'h0000_0000, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0};
        vecs[5]  = '{C_SRL, 32'h0000_0000, 32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0};
        vecs[6]  = '{C_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0,  32'h00F0_00F0, 1'b0};
        vecs[7]  = '{C_OR,  32'h1234_0000, 32'h0000_5678, 5'd0,  32'h1234_5678, 1'b0};
        vecs[8]  = '{C_XOR, 32'hFFFF_0000, 32'hFF00_FF00, 5'd0,  32'h00FF_FF00, 1'b0};
        vecs[9]  = '{C_SLL, 32'h0000_0000, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0};
        vecs[10] = '{C_SLT, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0,  32'h0000_0000, 1'b1};
        vecs[11] = '{4'b0011, 32'h0000_0005, 32'h0000_0006, 5'd3, 32'h0000_0000, 1'b1};
        vecs[12] = '{C_SUB, 32'h0000_0000, 32'h0000_0001, 5'd0,  32'hFFFF_FFFF, 1'b0};
        vecs[13] = '{4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0000, 1'b1};

        bus.in_valid    = 1'b0;
        bus.flush       = 1'b0;
        bus.alu_control = 4'd0;
        bus.src_a       = '0;
        bus.src_b       = '0;
        bus.shamt       = '0;
        rst_n           = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_md_done", 64'(bus.md_done), 64'd0);
        check("reset_hi", 64'(bus.hi), 64'd0);
        check("reset_lo", 64'(bus.lo), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            bus.alu_control = vecs[i].code;
            bus.src_a       = vecs[i].a;
            bus.src_b       = vecs[i].b;
            bus.shamt       = vecs[i].sh;
            bus.in_valid    = 1'b1;
            #1;
            check($sformatf("vec%0d_result", i), 64'(bus.result), 64'(vecs[i].res));
            check($sformatf("vec%0d_zero", i), 64'(bus.zero), 64'(vecs[i].z));
            check($sformatf("vec%0d_busy", i), 64'(bus.busy), 64'd0);
            @(posedge clk);
            #1;
        end

        for (int i = 0; i < 150; i++) begin
            c  = 4'($urandom_range(0, 15));
            a  = rnd_word();
            b  = rnd_word();
            sh = 5'($urandom_range(0, 31));
            bus.alu_control = c;
            bus.src_a       = a;
            bus.src_b       = b;
            bus.shamt       = sh;
            bus.in_valid    = (c == C_MUL || c == C_DIV) ? 1'b0 : 1'($urandom_range(0, 1));
            exp = ref_alu(c, a, b, sh);
            #1;
            check($sformatf("rnd%0d_op%0h_result", i, c), 64'(bus.result), 64'(exp));
            check($sformatf("rnd%0d_zero", i), 64'(bus.zero), 64'(exp == 32'd0));
            check($sformatf("rnd%0d_busy", i), 64'(bus.busy), 64'd0);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.shamt    = '0;

        run_md("mult_m3x7", C_MUL, 32'hFFFF_FFFD, 32'd7, 1'b0);
        run_md("div_7_m2", C_DIV, 32'd7, 32'hFFFF_FFFE, 1'b1);
        run_md("div_5_0", C_DIV, 32'd5, 32'd0, 1'b1);
        run_md("div_min_m1", C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_md("mult_min_min", C_MUL, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_md("div_neg_0", C_DIV, 32'hFFFF_FFF6, 32'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            run_md($sformatf("rnd_md%0d", i), (i % 2 == 0) ? C_MUL : C_DIV, rnd_word(), rnd_word(),
                   1'($urandom_range(0, 1)));
        end

        // Flush in the accept cycle: nothing starts.
        bus.alu_control = C_MUL;
        bus.src_a       = 32'd3;
        bus.src_b       = 32'd4;
        bus.in_valid    = 1'b1;
        bus.flush       = 1'b1;
        #1;
        check("flush_start_busy", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        #1;
        check("flush_start_no_run", 64'(bus.busy), 64'd0);

        run_md("preload", C_DIV, 32'h0444_5111, 32'h0000_2000, 1'b0);
        check("preload_hi", 64'(bus.hi), 64'h1111);
        check("preload_lo", 64'(bus.lo), 64'h2222);
        hold_hi = bus.hi;
        hold_lo = bus.lo;

        // MULT flushed at t+10.
        bus.alu_control = C_MUL;
        bus.src_a       = 32'd9;
        bus.src_b       = 32'd9;
        bus.in_valid    = 1'b1;
        #1;
        check("flushmul_accept_busy", 64'(bus.busy), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        #1;
        check("flushmul_t10_busy", 64'(bus.busy), 64'd1);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        #1;
        check("flushmul_t11_busy", 64'(bus.busy), 64'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.md_done || bus.busy) done_seen++;
        end
        check("flushmul_no_activity", 64'(done_seen), 64'd0);
        check("flushmul_hi", 64'(bus.hi), 64'(hold_hi));
        check("flushmul_lo", 64'(bus.lo), 64'(hold_lo));

        // Reset asserted at t+20 of a DIV.
        bus.alu_control = C_DIV;
        bus.src_a       = 32'd100;
        bus.src_b       = 32'd7;
        bus.in_valid    = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rstmid_busy", 64'(bus.busy), 64'd0);
        check("rstmid_md_done", 64'(bus.md_done), 64'd0);
        check("rstmid_hi", 64'(bus.hi), 64'd0);
        check("rstmid_lo", 64'(bus.lo), 64'd0);
        run_md("post_rst_mult", C_MUL, 32'hFFFF_FFF9, 32'h0001_0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
